// File: rtl/cache_tag_controller.sv
// Lookup/update controller for a 4-way set-associative tag bank with writeback/refill handshakes.
// Optional hit/miss/writeback counters are enabled by defining CACHE_STATS_EN.
module cache_tag_controller #(
  parameter int TAG_W = 11,
  parameter int IDX_W = 10,
  parameter int OFF_W = 3
) (
  input  logic                         CLK,
  input  logic                         Reset_n,
  input  logic                         Cpu_Valid,
  input  logic                         Cpu_Write,
  input  logic [TAG_W+IDX_W+OFF_W-1:0] Cpu_Addr,
  output logic                         Cpu_Done,
  output logic                         Cpu_Hit,
  output logic [IDX_W-1:0]             Tag_Line,
  output logic                         Tag_CEn,
  output logic                         Tag_WEn,
  output logic [TAG_W+2:0]             Tag_Wr0,
  output logic [TAG_W+2:0]             Tag_Wr1,
  output logic [TAG_W+2:0]             Tag_Wr2,
  output logic [TAG_W+2:0]             Tag_Wr3,
  input  logic [TAG_W+2:0]             Tag_Rd0,
  input  logic [TAG_W+2:0]             Tag_Rd1,
  input  logic [TAG_W+2:0]             Tag_Rd2,
  input  logic [TAG_W+2:0]             Tag_Rd3,
  output logic                         Mem_Req,
  output logic                         Mem_Wr,
  output logic [TAG_W+IDX_W-1:0]       Mem_Addr,
  input  logic                         Mem_Ack
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]                  Stat_Hits,
  output logic [15:0]                  Stat_Misses,
  output logic [15:0]                  Stat_Writebacks
`endif
);

  localparam int ENT_W = TAG_W + 3;
  localparam int INV   = TAG_W + 2;
  localparam int DRT   = TAG_W + 1;
  localparam int LU    = TAG_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, COMPARE, WRITEBACK, REFILL, UPDATE} state_t;

  state_t           state, stateNxt;
  logic [TAG_W-1:0] reqTag;
  logic [IDX_W-1:0] reqIdx;
  logic             reqWrite;
  logic [ENT_W-1:0] setReg [4];
  logic             hitReg;
  logic [1:0]       wayReg;

  logic [ENT_W-1:0] rdSet [4];
  logic [ENT_W-1:0] wrSet [4];
  logic             hitAny, invAny, luAny, victimWb, newDirty;
  logic [1:0]       hitWay, invWay, luWay, victimWay;

  assign rdSet[0] = Tag_Rd0;
  assign rdSet[1] = Tag_Rd1;
  assign rdSet[2] = Tag_Rd2;
  assign rdSet[3] = Tag_Rd3;

  // Descending scans so the lowest matching way is the one left standing.
  always_comb begin
    hitAny = 1'b0;
    hitWay = 2'd0;
    invAny = 1'b0;
    invWay = 2'd0;
    luAny  = 1'b0;
    luWay  = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (!rdSet[w][INV] && (rdSet[w][TAG_W-1:0] == reqTag)) begin
        hitAny = 1'b1;
        hitWay = 2'(w);
      end
      if (rdSet[w][INV]) begin
        invAny = 1'b1;
        invWay = 2'(w);
      end
      if (!rdSet[w][LU]) begin
        luAny = 1'b1;
        luWay = 2'(w);
      end
    end
    victimWay = invAny ? invWay : (luAny ? luWay : 2'd0);
    victimWb  = rdSet[victimWay][DRT] && !rdSet[victimWay][INV];
  end

  always_comb begin
    newDirty = reqWrite | (hitReg & setReg[wayReg][DRT]);
    for (int w = 0; w < 4; w++) begin
      if (2'(w) == wayReg) begin
        wrSet[w] = {1'b0, newDirty, 1'b1, reqTag};
      end else begin
        wrSet[w] = {setReg[w][INV], setReg[w][DRT], 1'b0, setReg[w][TAG_W-1:0]};
      end
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      reqTag   <= '0;
      reqIdx   <= '0;
      reqWrite <= 1'b0;
      hitReg   <= 1'b0;
      wayReg   <= 2'd0;
      for (int w = 0; w < 4; w++) setReg[w] <= '0;
    end else begin
      state <= stateNxt;
      if (state == IDLE && Cpu_Valid) begin
        reqTag   <= Cpu_Addr[TAG_W+IDX_W+OFF_W-1:IDX_W+OFF_W];
        reqIdx   <= Cpu_Addr[IDX_W+OFF_W-1:OFF_W];
        reqWrite <= Cpu_Write;
      end
      if (state == COMPARE) begin
        for (int w = 0; w < 4; w++) setReg[w] <= rdSet[w];
        hitReg <= hitAny;
        wayReg <= hitAny ? hitWay : victimWay;
      end
    end
  end

  always_comb begin
    stateNxt = state;
    Cpu_Done = 1'b0;
    Cpu_Hit  = 1'b0;
    Tag_CEn  = 1'b1;
    Tag_WEn  = 1'b1;
    Tag_Line = '0;
    Mem_Req  = 1'b0;
    Mem_Wr   = 1'b0;
    Mem_Addr = '0;
    case (state)
      IDLE: if (Cpu_Valid) stateNxt = LOOKUP;
      LOOKUP: begin
        Tag_CEn  = 1'b0;
        Tag_Line = reqIdx;
        stateNxt = COMPARE;
      end
      COMPARE: stateNxt = hitAny ? UPDATE : (victimWb ? WRITEBACK : REFILL);
      WRITEBACK: begin
        Mem_Req  = 1'b1;
        Mem_Wr   = 1'b1;
        Mem_Addr = {setReg[wayReg][TAG_W-1:0], reqIdx};
        if (Mem_Ack) stateNxt = REFILL;
      end
      REFILL: begin
        Mem_Req  = 1'b1;
        Mem_Addr = {reqTag, reqIdx};
        if (Mem_Ack) stateNxt = UPDATE;
      end
      UPDATE: begin
        Tag_CEn  = 1'b0;
        Tag_WEn  = 1'b0;
        Tag_Line = reqIdx;
        Cpu_Done = 1'b1;
        Cpu_Hit  = hitReg;
        stateNxt = IDLE;
      end
      default: stateNxt = IDLE;
    endcase
  end

  assign Tag_Wr0 = (state == UPDATE) ? wrSet[0] : '0;
  assign Tag_Wr1 = (state == UPDATE) ? wrSet[1] : '0;
  assign Tag_Wr2 = (state == UPDATE) ? wrSet[2] : '0;
  assign Tag_Wr3 = (state == UPDATE) ? wrSet[3] : '0;

  // Offset bits never affect tag handling; stored Last-used bits are rewritten, never read.
  logic unusedBits;
  assign unusedBits = ^{Cpu_Addr[OFF_W-1:0], setReg[0][LU], setReg[1][LU], setReg[2][LU], setReg[3][LU]};

`ifdef CACHE_STATS_EN
  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      Stat_Hits       <= '0;
      Stat_Misses     <= '0;
      Stat_Writebacks <= '0;
    end else begin
      if (state == UPDATE && hitReg)  Stat_Hits       <= satInc(Stat_Hits);
      if (state == UPDATE && !hitReg) Stat_Misses     <= satInc(Stat_Misses);
      if (state == WRITEBACK && Mem_Ack) Stat_Writebacks <= satInc(Stat_Writebacks);
    end
  end
`endif

endmodule

// File: tb/tb_cache_tag_controller.sv
// Bench for cache_tag_controller: directed vector table, reset-in-refill sequence, randomized
// requests against a behavioural model of hit detection, victim choice and set update.
module tb_cache_tag_controller;

  logic             CLK = 1'b0;
  logic             Reset_n = 1'b0;
  logic             Cpu_Valid = 1'b0;
  logic             Cpu_Write = 1'b0;
  logic [23:0]      Cpu_Addr = '0;
  logic             Mem_Ack = 1'b0;
  logic             Cpu_Done, Cpu_Hit, Tag_CEn, Tag_WEn, Mem_Req, Mem_Wr;
  logic [9:0]       Tag_Line;
  logic [20:0]      Mem_Addr;
  logic [13:0]      Tag_Wr0, Tag_Wr1, Tag_Wr2, Tag_Wr3;
  logic [3:0][13:0] rdBus = '0;

  cache_tag_controller dut (
    .CLK(CLK), .Reset_n(Reset_n), .Cpu_Valid(Cpu_Valid), .Cpu_Write(Cpu_Write),
    .Cpu_Addr(Cpu_Addr), .Cpu_Done(Cpu_Done), .Cpu_Hit(Cpu_Hit), .Tag_Line(Tag_Line),
    .Tag_CEn(Tag_CEn), .Tag_WEn(Tag_WEn), .Tag_Wr0(Tag_Wr0), .Tag_Wr1(Tag_Wr1),
    .Tag_Wr2(Tag_Wr2), .Tag_Wr3(Tag_Wr3), .Tag_Rd0(rdBus[0]), .Tag_Rd1(rdBus[1]),
    .Tag_Rd2(rdBus[2]), .Tag_Rd3(rdBus[3]), .Mem_Req(Mem_Req), .Mem_Wr(Mem_Wr),
    .Mem_Addr(Mem_Addr), .Mem_Ack(Mem_Ack)
  );

  always #5 CLK = ~CLK;

  // Synchronous tag bank model: read data appears one cycle after a read, junk otherwise.
  logic [3:0][13:0] bank [1024];
  logic             cenS = 1'b1, wenS = 1'b1;
  logic [9:0]       lineS = '0;
  always @(negedge CLK) begin
    cenS  <= Tag_CEn;
    wenS  <= Tag_WEn;
    lineS <= Tag_Line;
  end
  always @(posedge CLK) begin
    if (!cenS && wenS) rdBus <= bank[lineS];
    else rdBus <= 56'({$urandom, $urandom});
  end

  typedef struct {
    logic [10:0]      tag;
    logic [9:0]       idx;
    bit               wr;
    int               dly;
    logic [3:0][13:0] ent;
    bit               expHit;
    int               expK;
    int               expNPh;
    logic [1:0]       expPhWr;
    logic [1:0][20:0] expPhAddr;
    logic [3:0][13:0] expWr;
  } vec_t;

  vec_t vecs[8];
  int nChecks = 0;
  int nErr = 0;

  int               gotK, gotNPh, gotNWr;
  bit               gotHit, gotStable;
  logic [1:0]       gotPhWr;
  logic [1:0][20:0] gotPhAddr;
  logic [9:0]       gotWLine;
  logic [55:0]      gotWData;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic vec_t mkVec(input logic [10:0] tag, input logic [9:0] idx, input bit wr,
                                 input int dly, input logic [55:0] ent, input bit eh, input int ek,
                                 input int enp, input logic [1:0] epw, input logic [41:0] epa,
                                 input logic [55:0] ewr);
    vec_t v;
    v.tag = tag; v.idx = idx; v.wr = wr; v.dly = dly; v.ent = ent;
    v.expHit = eh; v.expK = ek; v.expNPh = enp; v.expPhWr = epw; v.expPhAddr = epa; v.expWr = ewr;
    return v;
  endfunction

  // Reference: first valid match hits; else invalid, then not-last-used, then way 0.
  function automatic vec_t modelVec(input logic [10:0] tag, input logic [9:0] idx, input bit wr,
                                    input int dly, input logic [3:0][13:0] e);
    vec_t v;
    int way;
    bit hit, wb;
    v.tag = tag; v.idx = idx; v.wr = wr; v.dly = dly; v.ent = e;
    hit = 1'b0;
    way = -1;
    for (int i = 0; i < 4; i++)
      if (way < 0 && !e[i][13] && e[i][10:0] == tag) begin hit = 1'b1; way = i; end
    if (!hit) begin
      for (int i = 0; i < 4; i++) if (way < 0 && e[i][13]) way = i;
      for (int i = 0; i < 4; i++) if (way < 0 && !e[i][11]) way = i;
      if (way < 0) way = 0;
    end
    wb = !hit && e[way][12] && !e[way][13];
    v.expHit = hit;
    v.expK = hit ? 2 : (wb ? 4 + 2 * dly : 3 + dly);
    v.expNPh = hit ? 0 : (wb ? 2 : 1);
    v.expPhWr = wb ? 2'b01 : 2'b00;
    v.expPhAddr = '0;
    if (wb) begin
      v.expPhAddr[0] = {e[way][10:0], idx};
      v.expPhAddr[1] = {tag, idx};
    end else if (!hit) begin
      v.expPhAddr[0] = {tag, idx};
    end
    for (int i = 0; i < 4; i++)
      v.expWr[i] = (i == way) ? {1'b0, wr | (hit & e[i][12]), 1'b1, tag}
                              : {e[i][13], e[i][12], 1'b0, e[i][10:0]};
    return v;
  endfunction

  task automatic doTxn(input logic [10:0] tag, input logic [9:0] idx, input bit wr, input int dly);
    int  k;
    int  cnt;
    bit  inPh;
    @(negedge CLK);
    Cpu_Addr = {tag, idx, 3'($urandom)};
    Cpu_Write = wr;
    Cpu_Valid = 1'b1;
    @(posedge CLK);
    #1 Cpu_Addr = 24'($urandom);
    gotK = -1; gotHit = 1'b0; gotNPh = 0; gotNWr = 0; gotStable = 1'b1;
    gotPhWr = '0; gotPhAddr = '0; gotWLine = '0; gotWData = '0;
    inPh = 1'b0;
    cnt = 0;
    k = 0;
    while (k < 200) begin
      @(negedge CLK);
      if (!Tag_WEn) begin
        gotNWr++;
        gotWLine = Tag_Line;
        gotWData = {Tag_Wr3, Tag_Wr2, Tag_Wr1, Tag_Wr0};
      end
      if (Mem_Req) begin
        if (!inPh) begin
          if (gotNPh < 2) begin
            gotPhWr[gotNPh] = Mem_Wr;
            gotPhAddr[gotNPh] = Mem_Addr;
          end
          gotNPh++;
          inPh = 1'b1;
          cnt = 0;
        end else if (gotNPh <= 2 && (Mem_Wr !== gotPhWr[gotNPh-1] || Mem_Addr !== gotPhAddr[gotNPh-1])) begin
          gotStable = 1'b0;
        end
        if (cnt == dly) begin
          Mem_Ack = 1'b1;
          inPh = 1'b0;
        end else begin
          Mem_Ack = 1'b0;
        end
        cnt++;
      end else begin
        inPh = 1'b0;
        Mem_Ack = ($urandom_range(0, 3) == 0);
      end
      if (Cpu_Done) begin
        gotK = k;
        gotHit = Cpu_Hit;
        break;
      end
      k++;
    end
    Cpu_Valid = 1'b0;
    Mem_Ack = 1'b0;
  endtask

  task automatic runVec(input string nm, input vec_t v);
    bank[v.idx] = v.ent;
    doTxn(v.tag, v.idx, v.wr, v.dly);
    chk({nm, ".doneCycle"}, gotK, v.expK);
    chk({nm, ".hit"}, gotHit, v.expHit);
    chk({nm, ".memPhases"}, gotNPh, v.expNPh);
    chk({nm, ".memWr"}, gotPhWr, v.expPhWr);
    chk({nm, ".memAddr"}, gotPhAddr, v.expPhAddr);
    chk({nm, ".memHeld"}, gotStable, 1);
    chk({nm, ".tagWrites"}, gotNWr, 1);
    chk({nm, ".tagLine"}, gotWLine, v.idx);
    chk({nm, ".tagData"}, gotWData, v.expWr);
  endtask

  initial begin
    logic [3:0][13:0] e;
    logic [10:0]      rt;
    bit               seen;
    int               badCyc;

    vecs[0] = mkVec(11'h123, 10'h005, 1'b0, 0, {14'h2000, 14'h0923, 14'h2000, 14'h2000},
                    1'b1, 2, 0, 2'b00, 42'h0, {14'h2000, 14'h0923, 14'h2000, 14'h2000});
    vecs[1] = mkVec(11'h123, 10'h005, 1'b1, 0, {14'h2000, 14'h0923, 14'h2000, 14'h2000},
                    1'b1, 2, 0, 2'b00, 42'h0, {14'h2000, 14'h1923, 14'h2000, 14'h2000});
    vecs[2] = mkVec(11'h123, 10'h005, 1'b0, 2, {14'h0844, 14'h0833, 14'h0022, 14'h0811},
                    1'b0, 5, 1, 2'b00, {21'h0, 21'h48C05}, {14'h0044, 14'h0033, 14'h0923, 14'h0011});
    vecs[3] = mkVec(11'h123, 10'h005, 1'b0, 5, {14'h0844, 14'h17FF, 14'h0822, 14'h0811},
                    1'b0, 14, 2, 2'b01, {21'h48C05, 21'h1FFC05}, {14'h0044, 14'h0923, 14'h0022, 14'h0011});
    vecs[4] = mkVec(11'h123, 10'h005, 1'b1, 1, {14'h2066, 14'h0822, 14'h0011, 14'h3055},
                    1'b0, 4, 1, 2'b00, {21'h0, 21'h48C05}, {14'h2066, 14'h0022, 14'h0011, 14'h1923});
    vecs[5] = mkVec(11'h123, 10'h3FF, 1'b0, 0, {14'h0844, 14'h0833, 14'h0822, 14'h1811},
                    1'b0, 4, 2, 2'b01, {21'h48FFF, 21'h047FF}, {14'h0044, 14'h0033, 14'h0022, 14'h0923});
    vecs[6] = mkVec(11'h123, 10'h2AA, 1'b0, 0, {14'h0923, 14'h0800, 14'h1123, 14'h2000},
                    1'b1, 2, 0, 2'b00, 42'h0, {14'h0123, 14'h0000, 14'h1923, 14'h2000});
    vecs[7] = mkVec(11'h123, 10'h001, 1'b0, 0, {14'h0833, 14'h0822, 14'h0811, 14'h2123},
                    1'b0, 3, 1, 2'b00, {21'h0, 21'h48C01}, {14'h0033, 14'h0022, 14'h0011, 14'h0923});

    for (int i = 0; i < 1024; i++) bank[i] = 56'({$urandom, $urandom});

    // Reset state
    @(negedge CLK);
    @(negedge CLK);
    chk("rst.cpu", {Cpu_Done, Cpu_Hit}, 2'b00);
    chk("rst.mem", {Mem_Req, Mem_Wr, Mem_Addr}, 23'h0);
    chk("rst.tagCtl", {Tag_CEn, Tag_WEn}, 2'b11);
    chk("rst.tagLine", Tag_Line, 10'h0);
    chk("rst.tagWr", {Tag_Wr3, Tag_Wr2, Tag_Wr1, Tag_Wr0}, 56'h0);
    Reset_n = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) runVec($sformatf("vec%0d", i), vecs[i]);

    // Reset asserted while a refill request is outstanding
    bank[10'h007] = {14'h0844, 14'h0833, 14'h0822, 14'h0811};
    @(negedge CLK);
    Cpu_Addr = {11'h123, 10'h007, 3'd0};
    Cpu_Write = 1'b1;
    Cpu_Valid = 1'b1;
    Mem_Ack = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge CLK);
      if (Mem_Req && !Mem_Wr) seen = 1'b1;
    end
    chk("rstRefill.reached", seen, 1);
    Reset_n = 1'b0;
    Cpu_Valid = 1'b0;
    #1;
    chk("rstRefill.memReq", {Mem_Req, Mem_Wr}, 2'b00);
    chk("rstRefill.memAddr", Mem_Addr, 21'h0);
    chk("rstRefill.tagCtl", {Tag_CEn, Tag_WEn, Cpu_Done}, 3'b110);
    @(negedge CLK);
    Reset_n = 1'b1;
    badCyc = 0;
    repeat (4) begin
      @(negedge CLK);
      if (!Tag_WEn || !Tag_CEn || Mem_Req || Cpu_Done) badCyc++;
    end
    chk("rstRefill.idleAfter", badCyc, 0);
    runVec("postRst", vecs[0]);

    // Randomized requests against the model
    for (int n = 0; n < 40; n++) begin
      rt = 11'($urandom_range(0, 3));
      for (int w = 0; w < 4; w++) begin
        e[w][13] = ($urandom_range(0, 3) == 0);
        e[w][12] = 1'($urandom);
        e[w][11] = 1'($urandom);
        e[w][10:0] = ($urandom_range(0, 2) == 0) ? rt : 11'($urandom_range(0, 7));
      end
      runVec($sformatf("rnd%0d", n), modelVec(rt, 10'($urandom), 1'($urandom), $urandom_range(0, 4), e));
    end

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
